// File: rtl/cpu_datapath.sv
// Register/bus datapath of the 8-bit teaching CPU: shared bus, PC/MAR/IR/A/B,
// ALU with flags, program RAM with a side load port, and the output register.
module cpu_datapath #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [14:0]   ctrlwrd,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [3:0]    instruction,
    output logic [DW-1:0] bus,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] areg,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          carry,
    output logic          zero,
    output logic          halted
);
    localparam int DEPTH = 1 << AW;

    logic j, co, ce, oi, bi, su, so, ao, ai, ii, io, ro, ri, mi, hlt;
    assign {hlt, mi, ri, ro, io, ii, ai, ao, so, su, bi, oi, ce, co, j} = ctrlwrd;

    logic [AW-1:0] pc_q, pc_d, mar_q;
    logic [DW-1:0] ir_q, a_q, b_q, out_q;
    logic          out_valid_q, carry_q, zero_q, halted_q;
    logic [DW-1:0] ram_q [DEPTH];

    logic [DW:0]   alu_full;
    logic [DW-1:0] alu_res;

    // Subtract is A + ~B + 1, so carry=1 means "no borrow" (A >= B).
    always_comb begin
        alu_full = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + {{DW{1'b0}}, su};
    end
    assign alu_res = alu_full[DW-1:0];

    always_comb begin
        bus = '0;
        if (co)      bus = {{(DW-AW){1'b0}}, pc_q};
        else if (ro) bus = ram_q[mar_q];
        else if (io) bus = {{(DW-4){1'b0}}, ir_q[3:0]};
        else if (ao) bus = a_q;
        else if (so) bus = alu_res;
    end

    always_comb begin
        pc_d = pc_q;
        if (j)       pc_d = bus[AW-1:0];
        else if (ce) pc_d = pc_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (!halted_q) begin
                pc_q <= pc_d;
                if (mi) mar_q <= bus[AW-1:0];
                if (ii) ir_q  <= bus;
                if (ai) a_q   <= bus;
                if (bi) b_q   <= bus;
                if (oi) begin
                    out_q       <= bus;
                    out_valid_q <= 1'b1;
                end
                if (so && ai) begin
                    carry_q <= alu_full[DW];
                    zero_q  <= (alu_res == '0);
                end
                if (hlt) halted_q <= 1'b1;
            end
        end
    end

    // RAM is not reset; the load port only acts while the core is idle or halted,
    // which keeps it from ever coinciding with an RI write.
    always_ff @(posedge clk) begin
        if (rstn && !halted_q && ri) begin
            ram_q[mar_q] <= bus;
        end else if (rstn && prog_we && (ctrlwrd == '0 || halted_q)) begin
            ram_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = ir_q[7:4];
    assign pc          = pc_q;
    assign areg        = a_q;
    assign out_data    = out_q;
    assign out_valid   = out_valid_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: control words change on the falling edge,
// expected values are queued at drive time and popped when the result is sampled.
module tb_cpu_datapath;
    localparam int DW = 8;
    localparam int AW = 4;

    localparam logic [14:0] J   = 15'h0001;
    localparam logic [14:0] CO  = 15'h0002;
    localparam logic [14:0] CE  = 15'h0004;
    localparam logic [14:0] OI  = 15'h0008;
    localparam logic [14:0] BI  = 15'h0010;
    localparam logic [14:0] SU  = 15'h0020;
    localparam logic [14:0] SO  = 15'h0040;
    localparam logic [14:0] AO  = 15'h0080;
    localparam logic [14:0] AI  = 15'h0100;
    localparam logic [14:0] II  = 15'h0200;
    localparam logic [14:0] IO  = 15'h0400;
    localparam logic [14:0] RO  = 15'h0800;
    localparam logic [14:0] RI  = 15'h1000;
    localparam logic [14:0] MI  = 15'h2000;
    localparam logic [14:0] HLT = 15'h4000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [14:0]   ctrlwrd = '0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic [3:0]    instruction;
    logic [DW-1:0] bus;
    logic [AW-1:0] pc;
    logic [DW-1:0] areg;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          carry;
    logic          zero;
    logic          halted;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    logic [63:0] obs_v;

    cpu_datapath #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .ctrlwrd(ctrlwrd),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .bus(bus), .pc(pc), .areg(areg),
        .out_data(out_data), .out_valid(out_valid), .carry(carry),
        .zero(zero), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic set_word(input logic [14:0] w);
        @(negedge clk);
        ctrlwrd = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [14:0] w);
        set_word(w);
        tick();
    endtask

    task automatic prog_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [14:0] w);
        @(negedge clk);
        ctrlwrd   = w;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        sb.push_back(64'h0);
        obs_v = 64'({instruction, bus, pc, areg, out_data, out_valid, carry, zero, halted});
        exp_v = sb.pop_front(); n_cmp++;
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_state: got %0h want %0h", obs_v, exp_v); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic preload_program();
        prog_load(4'd0,  8'h1E, '0);
        prog_load(4'd1,  8'h2F, '0);
        prog_load(4'd2,  8'h3D, '0);
        prog_load(4'd3,  8'h6C, '0);
        prog_load(4'd4,  8'h63, '0);
        prog_load(4'd12, 8'h2A, '0);
        prog_load(4'd13, 8'd5,  '0);
        prog_load(4'd14, 8'd200, '0);
        prog_load(4'd15, 8'd100, '0);
    endtask

    task automatic test_fetch();
        set_word(MI | CO);
        sb.push_back(64'h00);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL fetch_bus_co: got %0h want %0h", bus, exp_v); end
        tick();
        set_word(RO | II | CE);
        sb.push_back(64'h1E);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL fetch_bus_ro: got %0h want %0h", bus, exp_v); end
        sb.push_back(64'h11);
        tick();
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({instruction, pc}) !== exp_v) begin n_bad++; $display("FAIL fetch_ir_pc: got %0h want %0h", {instruction, pc}, exp_v); end
    endtask

    task automatic test_add_carry();
        apply(MI | IO);
        sb.push_back(64'd200);
        apply(RO | AI);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(areg) !== exp_v) begin n_bad++; $display("FAIL lda_a: got %0h want %0h", areg, exp_v); end
        apply(MI | CO);
        apply(RO | II | CE);
        apply(MI | IO);
        apply(RO | BI);
        set_word(SO | AI);
        sb.push_back(64'd44);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL add_bus: got %0h want %0h", bus, exp_v); end
        sb.push_back({54'd0, 8'd44, 1'b1, 1'b0});
        tick();
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({areg, carry, zero}) !== exp_v) begin n_bad++; $display("FAIL add_flags: got %0h want %0h", {areg, carry, zero}, exp_v); end
    endtask

    task automatic test_sub_zero();
        apply(MI | CO);
        apply(RO | II | CE);
        apply(MI | IO);
        apply(RO | AI | BI);
        sb.push_back({54'd0, 8'd0, 1'b1, 1'b1});
        apply(SO | SU | AI);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({areg, carry, zero}) !== exp_v) begin n_bad++; $display("FAIL sub_zero: got %0h want %0h", {areg, carry, zero}, exp_v); end
        set_word(SO);
        sb.push_back(64'd5);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL so_only_bus: got %0h want %0h", bus, exp_v); end
        sb.push_back({54'd0, 8'd0, 1'b1, 1'b1});
        tick();
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({areg, carry, zero}) !== exp_v) begin n_bad++; $display("FAIL flags_hold: got %0h want %0h", {areg, carry, zero}, exp_v); end
        sb.push_back({54'd0, 8'hFB, 1'b0, 1'b0});
        apply(SO | SU | AI);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({areg, carry, zero}) !== exp_v) begin n_bad++; $display("FAIL sub_borrow: got %0h want %0h", {areg, carry, zero}, exp_v); end
    endtask

    task automatic test_out_jmp();
        apply(MI | CO);
        apply(RO | II | CE);
        apply(MI | IO);
        apply(RO | AI);
        sb.push_back({55'd0, 8'h2A, 1'b1});
        apply(AO | OI);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({out_data, out_valid}) !== exp_v) begin n_bad++; $display("FAIL out_load: got %0h want %0h", {out_data, out_valid}, exp_v); end
        sb.push_back({55'd0, 8'h2A, 1'b0});
        apply('0);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({out_data, out_valid}) !== exp_v) begin n_bad++; $display("FAIL out_pulse: got %0h want %0h", {out_data, out_valid}, exp_v); end
        apply(MI | CO);
        apply(RO | II | CE);
        sb.push_back({56'd0, 4'h6, 4'h3});
        apply(IO | J | CE);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({instruction, pc}) !== exp_v) begin n_bad++; $display("FAIL jmp_pc: got %0h want %0h", {instruction, pc}, exp_v); end
        sb.push_back(64'hA);
        apply(AO | J);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(pc) !== exp_v) begin n_bad++; $display("FAIL jmp_from_a: got %0h want %0h", pc, exp_v); end
        for (int i = 0; i < 5; i++) apply(CE);
        sb.push_back(64'hF);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(pc) !== exp_v) begin n_bad++; $display("FAIL pc_max: got %0h want %0h", pc, exp_v); end
        sb.push_back({62'd0, 1'b0, 1'b0});
        apply(CE);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({pc, carry, zero}) !== exp_v) begin n_bad++; $display("FAIL pc_wrap: got %0h want %0h", {pc, carry, zero}, exp_v); end
    endtask

    task automatic test_ram_write();
        apply(MI | CO);
        apply(AO | RI);
        set_word(RO);
        sb.push_back(64'h2A);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL ri_write: got %0h want %0h", bus, exp_v); end
        apply(RO | RI);
        set_word(RO);
        sb.push_back(64'h2A);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL ro_ri_self: got %0h want %0h", bus, exp_v); end
        prog_load(4'd0, 8'h55, CO);
        set_word(RO);
        sb.push_back(64'h2A);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prog_blocked: got %0h want %0h", bus, exp_v); end
    endtask

    task automatic test_halt();
        sb.push_back(64'h1);
        apply(HLT);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(halted) !== exp_v) begin n_bad++; $display("FAIL halt_set: got %0h want %0h", halted, exp_v); end
        set_word(AI | CO | CE | OI);
        sb.push_back(64'h0);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL halt_bus: got %0h want %0h", bus, exp_v); end
        sb.push_back({49'd0, 1'b1, 8'h2A, 4'h0, 1'b0, 1'b0});
        tick();
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({halted, areg, pc, out_valid, zero}) !== exp_v) begin n_bad++; $display("FAIL halt_suppress: got %0h want %0h", {halted, areg, pc, out_valid, zero}, exp_v); end
        prog_load(4'd0, 8'h77, CO);
        set_word(RO);
        sb.push_back(64'h77);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL halt_prog: got %0h want %0h", bus, exp_v); end
        @(negedge clk);
        ctrlwrd = '0;
        rstn = 1'b0;
        #1;
        sb.push_back(64'h0);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({halted, pc, areg}) !== exp_v) begin n_bad++; $display("FAIL halt_reset: got %0h want %0h", {halted, pc, areg}, exp_v); end
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_bus_priority();
        sb.push_back(64'h7);
        apply(RO | J);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(pc) !== exp_v) begin n_bad++; $display("FAIL prio_setup_pc: got %0h want %0h", pc, exp_v); end
        set_word(CO | AO | SO);
        sb.push_back(64'h07);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prio_co: got %0h want %0h", bus, exp_v); end
        apply(RO | AI);
        apply(RO | II);
        set_word(RO | IO | AO | SO);
        sb.push_back(64'h77);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prio_ro: got %0h want %0h", bus, exp_v); end
        set_word(IO | AO | SO);
        sb.push_back(64'h07);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prio_io: got %0h want %0h", bus, exp_v); end
        set_word(AO | SO);
        sb.push_back(64'h77);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prio_ao: got %0h want %0h", bus, exp_v); end
        set_word(SO);
        sb.push_back(64'h77);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL prio_so: got %0h want %0h", bus, exp_v); end
        set_word('0);
        sb.push_back(64'h00);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL bus_idle: got %0h want %0h", bus, exp_v); end
        sb.push_back({55'd0, 8'h77, 1'b1});
        apply(AO | OI);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'({out_data, out_valid}) !== exp_v) begin n_bad++; $display("FAIL prio_out: got %0h want %0h", {out_data, out_valid}, exp_v); end
        #2;
        rstn = 1'b0;
        #1;
        sb.push_back(64'h0);
        exp_v = sb.pop_front(); n_cmp++;
        obs_v = 64'({instruction, pc, areg, out_data, out_valid, carry, zero, halted});
        if (obs_v !== exp_v) begin n_bad++; $display("FAIL midcycle_reset: got %0h want %0h", obs_v, exp_v); end
        @(negedge clk);
        ctrlwrd = '0;
        rstn = 1'b1;
        set_word(RO);
        sb.push_back(64'h77);
        exp_v = sb.pop_front(); n_cmp++;
        if (64'(bus) !== exp_v) begin n_bad++; $display("FAIL ram_kept: got %0h want %0h", bus, exp_v); end
    endtask

    initial begin
        test_reset();
        preload_program();
        test_fetch();
        test_add_carry();
        test_sub_zero();
        test_out_jmp();
        test_ram_write();
        test_halt();
        test_bus_priority();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Register/bus datapath of the 8-bit teaching CPU, directly downstream of the instruction-stage controller. Consumes the controller's 15-bit control word each cycle, drives the shared 8-bit bus, and updates PC, MAR, RAM, IR, A, B, flags and the output register. Returns the IR opcode nibble to the controller, closing the fetch/execute loop. A side port preloads program RAM.

## Interface
- DW, 8, data/bus width
- AW, 4, address width (RAM depth 2^AW = 16)

- clk  in  1  system clock; datapath state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- ctrlwrd  in  15  control word: bit0 J, 1 CO, 2 CE, 3 OI, 4 BI, 5 SU, 6 SO, 7 AO, 8 AI, 9 II, 10 IO, 11 RO, 12 RI, 13 MI, 14 HLT
- prog_we  in  1  program-load write strobe
- prog_addr  in  AW  program-load address
- prog_data  in  DW  program-load data
- instruction  out  4  IR[7:4], opcode to controller
- bus  out  DW  current bus value (combinational, for LEDs/debug)
- pc  out  AW  program counter
- areg  out  DW  register A
- out_data  out  DW  output register
- out_valid  out  1  one-cycle pulse after an OI load
- carry  out  1  carry flag
- zero  out  1  zero flag
- halted  out  1  sticky halt indicator

## Operation
- Bus driver is combinational, fixed priority CO > RO > IO > AO > SO; no driver asserted -> bus = 0. CO drives {0,pc}; RO drives ram[mar]; IO drives {0,IR[3:0]}; AO drives A; SO drives ALU result.
- ALU: SU=0 -> A+B; SU=1 -> A+~B+1. Computed at DW+1 bits; result = low DW bits, carry-out = bit DW. Subtract with A>=B gives carry=1.
- Rising-edge register updates, all sampling the same bus value:
  - MI: mar <= bus[AW-1:0]
  - RI: ram[mar] <= bus, using the pre-edge mar
  - II: ir <= bus
  - AI: A <= bus
  - BI: B <= bus
  - OI: out_data <= bus; out_valid <= 1 for exactly one cycle
  - CE: pc <= pc+1, wrapping 15 -> 0
  - J: pc <= bus[AW-1:0]; J overrides CE when both are set
  - Flags: load carry and zero (result==0) only when SO and AI are both set; otherwise hold.
  - HLT: halted <= 1, sticky until reset.
- While halted=1, all register, flag and RAM writes from ctrlwrd are suppressed; bus stays combinational.
- prog_we writes ram[prog_addr] <= prog_data only when ctrlwrd==0 or halted=1; otherwise ignored. A concurrent RI never collides with it.
- instruction = ir[7:4] at all times.

## Timing
- The controller changes ctrlwrd on the falling edge of clk, and the datapath samples on the rising edge. Each control word therefore has half a cycle to settle and takes effect on exactly one rising edge.
- Register latency is 1 edge. A value written by one control word is visible on the bus for the next control word.
- Async reset (rstn=0) clears pc, mar, ir, A, B, out_data, out_valid, carry, zero and halted to 0 immediately. RAM contents are not reset.
- Reset mid-instruction: all registers clear immediately. After release, the first rising edge acts on whatever ctrlwrd is present; fetch restarts from pc=0.
- RO with RI in one word writes ram[mar] with its own value (no change).
- pc wrap: pc=15 with CE -> 0, no flag effect.

## Test plan
- Fetch: preload ram[0]=0x1E; apply MI|CO, then RO|II|CE -> mar=0, ir=0x1E, instruction=1, pc=1.
- LDA/ADD with carry: ram[14]=200, ram[15]=100, A=200. Apply MI|IO (IR[3:0]=15), then RO|BI, then SO|AI -> A=44, carry=1, zero=0.
- SUB to zero: A=5, B=5, apply SO|SU|AI -> A=0, carry=1, zero=1. Then a word with SO only -> flags unchanged.
- OUT and JMP: A=0x2A, apply AO|OI -> out_data=0x2A and out_valid high for one cycle. IR=0x63, apply IO|J|CE -> pc=3 (J wins).
- Halt: apply HLT, then AI with CO -> halted=1 and A unchanged. prog_we now writes RAM. rstn pulse -> halted=0, pc=0.
- Bus priority and reset: assert CO|AO|SO with pc=7 -> bus=0x07. Drop rstn mid-cycle -> all registers 0 before the next edge, RAM intact.
